ifetch_prefetch: RTL

- Instruction fetch front end that sits directly upstream of the single-cycle RV32I core.
- Owns the fetch PC and issues in-order word reads to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions with their PCs in a small FIFO and presents them to the core over a valid/ready handshake.
- On a core redirect (taken branch, jal/jalr), flushes the FIFO and discards stale in-flight responses.

---
 rtl/ifetch_prefetch.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ifetch_prefetch.sv
// Instruction fetch front end: issues in-order word reads, buffers responses with their PCs
// in a small FIFO and hands them to the core; redirects flush and drop stale responses.
module ifetch_prefetch #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   output logic        busy
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   rsp_pc_q, rsp_pc_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [31:0]   data_q [DEPTH];
   logic [31:0]   data_d [DEPTH];
   logic [31:0]   pc_q   [DEPTH];
   logic [31:0]   pc_d   [DEPTH];

   logic [CW:0]   credit;
   logic [31:0]   redirect_aligned;
   logic          req_ok, req_fire, rsp_ok, drop, push, pop;

   always_comb begin
      credit           = {1'b0, outstanding_q} + {1'b0, count_q};
      redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
      // Credits cover both buffered and in-flight words, so a push always has a free slot.
      req_ok   = rst_n && !redirect_valid && (credit < (CW+1)'(DEPTH));
      req_fire = req_ok && imem_req_ready;
      rsp_ok   = imem_rsp_valid && (outstanding_q != '0);
      drop     = rsp_ok && (drop_cnt_q != '0);
      push     = rsp_ok && !drop && !redirect_valid;
      pop      = (count_q != '0) && inst_ready && !redirect_valid;

      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_ok);
      count_d       = count_q;
      drop_cnt_d    = drop_cnt_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      data_d        = data_q;
      pc_d          = pc_q;

      if (redirect_valid) begin
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         fetch_pc_d = redirect_aligned;
         rsp_pc_d   = redirect_aligned;
         drop_cnt_d = outstanding_q - CW'(rsp_ok);
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (push) begin
            data_d[wr_ptr_q] = imem_rsp_data;
            pc_d[wr_ptr_q]   = rsp_pc_q;
            wr_ptr_d         = wr_ptr_q + 1'b1;
            rsp_pc_d         = rsp_pc_q + 32'd4;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (drop) begin
            drop_cnt_d = drop_cnt_q - 1'b1;
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         count_q       <= '0;
         drop_cnt_q    <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            data_q[i] <= NOP;
            pc_q[i]   <= RESET_PC;
         end
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         count_q       <= count_d;
         drop_cnt_q    <= drop_cnt_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         data_q        <= data_d;
         pc_q          <= pc_d;
      end
   end

   always_comb begin
      imem_req_valid = req_ok;
      imem_req_addr  = fetch_pc_q;
      inst_valid     = (count_q != '0);
      inst_data      = inst_valid ? data_q[rd_ptr_q] : NOP;
      // When empty, show the PC the next buffered word will carry.
      inst_pc        = inst_valid ? pc_q[rd_ptr_q] : rsp_pc_q;
      busy           = (outstanding_q != '0);
   end

endmodule
